clock_sequencer: RTL

Single-clock run/halt/single-step controller that generates the processor's microcode and CPU clock enables from the board clock with a programmable division ratio. It replaces derived (ripple) clocks with one-cycle enable pulses on `clock_in`, so all CPU and microcode logic stays in one clock domain. It sits between the debug/control interface (run, step, ratio programming) and the CPU core. One CPU cycle is always exactly 4 microcode ticks.

---
 rtl/clock_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/clock_sequencer.sv
// Run/halt/single-step controller that turns the board clock into one-cycle
// microcode and CPU tick enables with a programmable division ratio. One CPU
// cycle is always four microcode ticks, and the sequencer only ever stops on a
// CPU-cycle boundary.
module clock_sequencer #(
   parameter logic [7:0] RESET_RATIO = 8'd24,
   parameter int         CNT_W       = 16
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             run,
   input  logic             step_req,
   input  logic [7:0]       ratio_in,
   input  logic             ratio_load,
   output logic             micro_en,
   output logic             cpu_en,
   output logic [1:0]       phase,
   output logic             halted,
   output logic [7:0]       ratio_active,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       div_q, div_d;
   logic [1:0]       phase_q, phase_d;
   logic             micro_en_q, micro_en_d;
   logic             cpu_en_q, cpu_en_d;
   logic             halted_q, halted_d;
   logic [7:0]       ratio_q, ratio_d;
   logic [7:0]       pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic at_boundary;
   logic hold_boundary;
   logic advance;
   logic tick;
   logic cpu_tick;

   // Decide whether the divider advances this edge and whether it ticks.
   always_comb begin
      // NOTE: every signal written here gets a value on every path (defaults
      // first in the blocks below), otherwise synthesis infers a latch.
      at_boundary   = (phase_q == 2'd0) && (div_q == 8'd0);
      // A run that is released exactly on a boundary stops without ticking.
      hold_boundary = (state_q == ST_RUN) && !run && at_boundary;
      advance       = (state_q != ST_HALTED) && !hold_boundary;
      tick          = advance && (div_q == ratio_q);
      cpu_tick      = tick && (phase_q == 2'd3);
   end

   // Divider, phase and cycle counter next values plus the tick enables.
   always_comb begin
      div_d      = div_q;
      phase_d    = phase_q;
      count_d    = count_q;
      micro_en_d = tick;
      cpu_en_d   = cpu_tick;
      if (advance) begin
         if (tick) begin
            div_d   = 8'd0;
            phase_d = phase_q + 2'd1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end
      if (cpu_tick) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Run/step/drain state machine; halting is only allowed on a CPU-cycle edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALTED: begin
            if (run) begin
               state_d = ST_RUN;
            end else if (step_req) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!run) begin
               state_d = (at_boundary || cpu_tick) ? ST_HALTED : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (run) begin
               state_d = ST_RUN;
            end else if (cpu_tick) begin
               state_d = ST_HALTED;
            end
         end
         ST_STEP: begin
            if (cpu_tick) begin
               state_d = run ? ST_RUN : ST_HALTED;
            end
         end
         default: state_d = ST_HALTED;
      endcase
      halted_d = (state_d == ST_HALTED);
   end

   // Ratio programming: changes land only while halted or on a CPU-cycle edge.
   always_comb begin
      ratio_d      = ratio_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (state_q == ST_HALTED) begin
         if (pend_valid_q) begin
            ratio_d      = pend_q;
            pend_valid_d = 1'b0;
         end
         if (ratio_load) begin
            pend_d       = ratio_in;
            pend_valid_d = 1'b1;
         end
      end else if (cpu_tick) begin
         // A load on the boundary edge itself bypasses the pending register.
         if (ratio_load) begin
            ratio_d = ratio_in;
         end else if (pend_valid_q) begin
            ratio_d = pend_q;
         end
         pend_valid_d = 1'b0;
      end else if (ratio_load) begin
         pend_d       = ratio_in;
         pend_valid_d = 1'b1;
      end
   end

   // State register; reset drops any partial cycle and any pending ratio.
   always_ff @(posedge clock_in or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge.
      if (reset) begin
         state_q      <= ST_HALTED;
         div_q        <= 8'd0;
         phase_q      <= 2'd0;
         micro_en_q   <= 1'b0;
         cpu_en_q     <= 1'b0;
         halted_q     <= 1'b1;
         ratio_q      <= RESET_RATIO;
         pend_q       <= 8'd0;
         pend_valid_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         phase_q      <= phase_d;
         micro_en_q   <= micro_en_d;
         cpu_en_q     <= cpu_en_d;
         halted_q     <= halted_d;
         ratio_q      <= ratio_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         count_q      <= count_d;
      end
   end

   assign micro_en     = micro_en_q;
   assign cpu_en       = cpu_en_q;
   assign phase        = phase_q;
   assign halted       = halted_q;
   assign ratio_active = ratio_q;
   assign cycle_count  = count_q;

endmodule
